bcd_display_ctrl: RTL and testbench

Sequential binary-to-BCD converter and display sequencer for the reaction-timer readout. It takes a binary millisecond count and runs a one-bit-per-cycle shift-add-3 (double-dabble) conversion. It then presents DIGITS registered BCD nibbles, one per downstream BCD_Decoder instance, plus a per-digit blank mask. It sits between the timer counter and the bank of seven-segment decoders.

---
 rtl/bcd_display_ctrl.sv | 142 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the digit decoders.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking; otherwise blank is all zeros.
module bcd_display_ctrl #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);
    // One spare scratch nibble so values up to 2^BIN_W-1 never spill into the low digits.
    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_W);

    // Handshake: start is accepted on any edge where busy=0; done pulses for one
    // cycle exactly when bcd_out/blank/overflow take their new values.
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    state_t                  state_n;
    logic [BIN_W-1:0]        shift_reg;
    logic [SW-1:0]           scratch;
    logic [SW-1:0]           adjusted;
    logic [SW-1:0]           scratch_n;
    logic [BIN_W-1:0]        shift_n;
    logic [SW+BIN_W-1:0]     wide_n;
    logic [CW-1:0]           cnt;
    logic                    ov_pend;
    logic                    accept;
    logic                    last;
    logic                    done_q;
    logic                    ov_q;
    logic [4*DIGITS-1:0]     bcd_q;
    logic [4*DIGITS-1:0]     result;

    assign accept = (state == IDLE) && start;
    assign last   = (state == SHIFT) && (cnt == CW'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        wide_n = {adjusted, shift_reg} << 1;
    end

    assign scratch_n = wide_n[SW+BIN_W-1:BIN_W];
    assign shift_n   = wide_n[BIN_W-1:0];
    assign result    = scratch_n[4*DIGITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ov_pend   <= 1'b0;
            done_q    <= 1'b0;
            ov_q      <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_reg <= bin_in;
                scratch   <= '0;
                cnt       <= '0;
                ov_pend   <= (bin_in > BIN_W'(MAX_VAL));
            end else if (state == SHIFT) begin
                shift_reg <= shift_n;
                scratch   <= scratch_n;
                cnt       <= cnt + CW'(1);
                if (last) begin
                    done_q <= 1'b1;
                    ov_q   <= ov_pend;
                    bcd_q  <= ov_pend ? {DIGITS{4'h9}} : result;
                end
            end
        end
    end

    assign done     = done_q;
    assign overflow = ov_q;
    assign bcd_out  = bcd_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_n;
    logic              zero_run;

    // A digit goes dark only when it and every digit above it are zero.
    always_comb begin
        blank_n  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (result[4*i +: 4] == 4'd0);
            blank_n[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (last) begin
            blank_q <= ov_pend ? '0 : blank_n;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: directed vector table, multi-cycle corner sequences and random values.
module tb_bcd_display_ctrl;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = 14;

    logic                clk;
    logic                reset;
    logic                start;
    logic [BIN_W-1:0]    bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   blank;
    logic                overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ov;
        logic [3:0]  blank_lz;
    } vec_t;

    vec_t tbl[12];
    logic [15:0] exp_q[$];

    bcd_display_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(9999)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank), .overflow(overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lz_or_zero(input logic [3:0] lz);
`ifdef LEADING_ZERO_BLANK_EN
        return lz;
`else
        return 4'b0000;
`endif
    endfunction

    // Reference model: decimal digits by division, blanking by magnitude.
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        if (v > 9999) return 16'h9999;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_blank(input int v);
        logic [3:0] b;
        int         p;
        b = 4'b0000;
        p = 10;
        if (v > 9999) return 4'b0000;
        for (int i = 1; i < 4; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return lz_or_zero(b);
    endfunction

    // Driver: start a conversion, optionally inject a late start (kind 1) or reset (kind 2)
    // at cycle inj_at, and return the done latency, or -1 when no done pulse arrives within 30 cycles.
    task automatic run_conv(input logic [13:0] v, input int inj_at, input int inj_kind,
                            output int lat, output int hold_err);
        logic [15:0] prev_bcd;
        logic [3:0]  prev_blank;
        logic        prev_ov;
        prev_bcd   = bcd_out;
        prev_blank = blank;
        prev_ov    = overflow;
        hold_err   = 0;
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'($urandom_range(0, 16383));
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!(inj_kind == 2 && c > inj_at)) begin
                if (bcd_out !== prev_bcd || blank !== prev_blank || overflow !== prev_ov)
                    hold_err++;
                if (busy !== 1'b1 && c < LAT) hold_err++;
            end
            if (c == inj_at) begin
                if (inj_kind == 1) begin
                    start  = 1'b1;
                    bin_in = 14'd8888;
                end else if (inj_kind == 2) begin
                    reset = 1'b1;
                end
            end else if (c == inj_at + 1) begin
                start = 1'b0;
                reset = 1'b0;
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] e_bcd, input logic e_ov,
                                input logic [3:0] e_blank, input int lat, input int hold_err);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_bcd"}, 32'(bcd_out), 32'(e_bcd));
        check({tag, "_ovf"}, 32'(overflow), 32'(e_ov));
        check({tag, "_blank"}, 32'(blank), 32'(e_blank));
        check({tag, "_hold"}, 32'(hold_err), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_out), 32'h0000);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_blank"}, 32'(blank), 32'(lz_or_zero(4'b1110)));
    endtask

    initial begin
        int lat;
        int herr;
        int v;
        logic [15:0] eb;

        tbl[0]  = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
        tbl[1]  = '{14'd7,     16'h0007, 1'b0, 4'b1110};
        tbl[2]  = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        tbl[3]  = '{14'd12000, 16'h9999, 1'b1, 4'b0000};
        tbl[4]  = '{14'd5,     16'h0005, 1'b0, 4'b1110};
        tbl[5]  = '{14'd0,     16'h0000, 1'b0, 4'b1110};
        tbl[6]  = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
        tbl[7]  = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
        tbl[8]  = '{14'd10,    16'h0010, 1'b0, 4'b1100};
        tbl[9]  = '{14'd100,   16'h0100, 1'b0, 4'b1000};
        tbl[10] = '{14'd42,    16'h0042, 1'b0, 4'b1100};
        tbl[11] = '{14'd9000,  16'h9000, 1'b0, 4'b0000};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        // Table vectors run back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_conv(tbl[i].bin, 0, 0, lat, herr);
            check_result($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].ov, lz_or_zero(tbl[i].blank_lz), lat, herr);
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);

        // Start while busy is ignored.
        run_conv(14'd1234, 0, 0, lat, herr);
        check_result("pre_ignore", 16'h1234, 1'b0, 4'b0000, lat, herr);
        run_conv(14'd42, 5, 1, lat, herr);
        check_result("ignore_start", 16'h0042, 1'b0, lz_or_zero(4'b1100), lat, herr);
        @(negedge clk);
        check("ignore_single_done", 32'(done), 32'd0);
        check("ignore_no_requeue", 32'(busy), 32'd0);

        // Reset mid-conversion aborts without a done pulse.
        run_conv(14'd4321, 7, 2, lat, herr);
        check("abort_no_done", 32'(lat), 32'hffff_ffff);
        check_reset_state("abort");
        run_conv(14'd50, 0, 0, lat, herr);
        check_result("after_abort", 16'h0050, 1'b0, lz_or_zero(4'b1100), lat, herr);

        // Random values against the decimal model.
        for (int i = 0; i < 24; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            exp_q.push_back(model_bcd(v));
            run_conv(14'(v), 0, 0, lat, herr);
            eb = exp_q.pop_front();
            check_result($sformatf("rand%0d_v%0d", i, v), eb, 1'(v > 9999), model_blank(v), lat, herr);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
